// File: rtl/smart_cargo_tx_status.sv
// smart_cargo_tx_status: UART 8N1 transmitter sending a 5-byte ASCII elevator status frame
module smart_cargo_tx_status #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int AUTO_ON_CHANGE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [1:0] andar_atual,
  input  logic [1:0] prox_parada,
  input  logic       motor_subindo,
  input  logic       motor_descendo,
  input  logic       emergencia,
  output logic       TX,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);
  localparam int BIT_TICKS = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT_TICKS + 1);
  typedef enum logic [3:0] {IDLE, LOAD, START, DATA, STOP, NEXT, FIM} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx, byte_idx;
  logic [7:0] shift, status, cur_byte;
  logic [6:0] live, snap, last_sent;
  logic valid, pending, changed, tick, stop_tick;
  assign live = {emergencia, motor_subindo, motor_descendo, prox_parada, andar_atual};
  assign changed = (AUTO_ON_CHANGE != 0) && (!valid || live != last_sent);
  assign tick = cnt == CW'(BIT_TICKS - 1);
  // STOP is one tick short because NEXT supplies the final stop-bit cycle
  assign stop_tick = cnt == CW'(BIT_TICKS - 2);
  assign db_estado = state;
  always_comb begin
    status = snap[6] ? 8'h45 : (snap[5] & snap[4]) ? 8'h58 : snap[5] ? 8'h53 : snap[4] ? 8'h44 : 8'h50;
    cur_byte = byte_idx == 3'd0 ? 8'h23 :
               byte_idx == 3'd1 ? {6'b001100, snap[1:0]} :
               byte_idx == 3'd2 ? {6'b001100, snap[3:2]} :
               byte_idx == 3'd3 ? status : 8'h0A;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift     <= '0;
      snap      <= '0;
      last_sent <= '0;
      valid     <= 1'b0;
      pending   <= 1'b0;
      TX        <= 1'b1;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      TX      <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      ocupado <= state != IDLE && state != FIM;
      pronto  <= state == FIM;
      if (state != IDLE && enviar) pending <= 1'b1;
      case (state)
        IDLE: if (enviar || pending || changed) begin
          state   <= LOAD;
          pending <= 1'b0;
        end
        LOAD: begin
          snap     <= live;
          byte_idx <= '0;
          cnt      <= '0;
          state    <= START;
        end
        START: if (tick) begin
          cnt     <= '0;
          bit_idx <= '0;
          shift   <= cur_byte;
          state   <= DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (tick) begin
          cnt     <= '0;
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (stop_tick) begin
          cnt   <= '0;
          state <= NEXT;
        end else cnt <= cnt + 1'b1;
        NEXT: if (byte_idx == 3'd4) state <= FIM;
        else begin
          byte_idx <= byte_idx + 3'd1;
          state    <= START;
        end
        FIM: begin
          last_sent <= snap;
          valid     <= 1'b1;
          if (pending || enviar) begin
            state   <= LOAD;
            pending <= 1'b0;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_smart_cargo_tx_status.sv
// tb_smart_cargo_tx_status: randomized scoreboard bench with UART frame decoding monitor
`timescale 1ns/1ps
module tb_smart_cargo_tx_status;
  localparam int T = 10;
  typedef logic [39:0] frame_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, en0, su0, de0, em0, tx0, oc0, pr0;
  logic rst1, en1, su1, de1, em1, tx1, oc1, pr1;
  logic [1:0] a0, p0, a1, p1;
  logic [3:0] db0, db1;
  int checks = 0, errors = 0;
  frame_t q0[$], q1[$];
  smart_cargo_tx_status #(.CLK_FREQ(1000), .BAUD(100), .AUTO_ON_CHANGE(0)) u0 (
    .clock(clk), .reset(rst0), .enviar(en0), .andar_atual(a0), .prox_parada(p0),
    .motor_subindo(su0), .motor_descendo(de0), .emergencia(em0),
    .TX(tx0), .ocupado(oc0), .pronto(pr0), .db_estado(db0));
  smart_cargo_tx_status #(.CLK_FREQ(1000), .BAUD(100), .AUTO_ON_CHANGE(1)) u1 (
    .clock(clk), .reset(rst1), .enviar(en1), .andar_atual(a1), .prox_parada(p1),
    .motor_subindo(su1), .motor_descendo(de1), .emergencia(em1),
    .TX(tx1), .ocupado(oc1), .pronto(pr1), .db_estado(db1));

  function automatic frame_t model(input int a, input int p, input bit s, input bit d, input bit e);
    byte st;
    st = e ? "E" : (s && d) ? "X" : s ? "S" : d ? "D" : "P";
    return {8'h23, 8'(8'h30 + a), 8'(8'h30 + p), st, 8'h0A};
  endfunction

  task automatic chk(input string n, input logic [39:0] got, input logic [39:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask

  // monitor: decodes both TX lines at mid-bit and compares whole frames with the queues
  logic [1:0] txv, rv;
  assign txv = {tx1, tx0};
  assign rv = {rst1, rst0};
  int tk[2], nb[2], mb;
  bit busy[2];
  logic [7:0] sh[2];
  frame_t cur[2], want;
  initial for (int i = 0; i < 2; i++) begin busy[i] = 0; nb[i] = 0; tk[i] = 0; end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rv[i] !== 1'b0) begin
        busy[i] = 0;
        nb[i] = 0;
      end else if (!busy[i]) begin
        if (txv[i] === 1'b0) begin busy[i] = 1; tk[i] = 0; end
      end else begin
        tk[i]++;
        if (tk[i] % T == T / 2) begin
          mb = tk[i] / T;
          if (mb == 0) begin
            if (txv[i] !== 1'b0) begin checks++; errors++; $display("FAIL start_bit dut%0d: got %b expected 0", i, txv[i]); busy[i] = 0; end
          end else if (mb <= 8) sh[i][mb-1] = txv[i];
          else begin
            busy[i] = 0;
            if (txv[i] !== 1'b1) begin checks++; errors++; $display("FAIL stop_bit dut%0d: got %b expected 1", i, txv[i]); end
            cur[i] = {cur[i][31:0], sh[i]};
            nb[i]++;
            if (nb[i] == 5) begin
              nb[i] = 0;
              if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame dut%0d: got %h expected none", i, cur[i]);
              end else begin
                want = i == 0 ? q0.pop_front() : q1.pop_front();
                chk($sformatf("frame_dut%0d", i), cur[i], want);
              end
            end
          end
        end
      end
    end
  end

  task automatic set0(input int a, input int p, input bit s, input bit d, input bit e);
    a0 = 2'(a); p0 = 2'(p); su0 = s; de0 = d; em0 = e;
  endtask

  task automatic send0(output int tf, output int tp);
    q0.push_back(model(a0, p0, su0, de0, em0));
    @(posedge clk); #1 en0 = 1;
    @(posedge clk); #1 en0 = 0;
    tf = -1; tp = -1;
    for (int c = 1; c <= 700 && tp < 0; c++) begin
      @(posedge clk); #1;
      if (tx0 === 1'b0 && tf < 0) tf = c;
      if (pr0 === 1'b1) tp = c;
    end
  endtask

  task automatic wait_pr1(output int tp);
    tp = -1;
    for (int c = 1; c <= 700 && tp < 0; c++) begin
      @(posedge clk); #1;
      if (pr1 === 1'b1) tp = c;
    end
  endtask

  int tf, tp, tf2, bad;
  initial begin
    rst0 = 1; rst1 = 1; en0 = 0; en1 = 0;
    set0(0, 0, 0, 0, 0);
    a1 = 0; p1 = 0; su1 = 0; de1 = 0; em1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx0, 1);
    chk("reset_ocupado", oc0, 0);
    chk("reset_pronto", pr0, 0);
    chk("reset_db_estado", db0, 0);
    chk("reset_tx_auto", tx1, 1);
    q1.push_back(model(0, 0, 0, 0, 0));
    rst0 = 0; rst1 = 0;
    bad = 0;
    repeat (200) begin @(posedge clk); #1; if (tx0 !== 1'b1 || oc0 !== 1'b0) bad++; end
    chk("idle_without_auto", bad, 0);

    set0(2, 3, 1, 0, 0);
    send0(tf, tp);
    chk("tx_fall_latency", tf, 2);
    chk("pronto_latency", tp, 502);
    set0(0, 1, 1, 0, 1);
    send0(tf, tp);
    chk("pronto_emergency", tp, 502);
    set0(3, 0, 1, 1, 0);
    send0(tf, tp);
    chk("pronto_both_motors", tp, 502);
    for (int n = 0; n < 6; n++) begin
      set0($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
      send0(tf, tp);
      chk($sformatf("pronto_random%0d", n), tp, 502);
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
    end

    // three requests during a frame collapse into one back-to-back frame with a new snapshot
    set0(1, 2, 0, 1, 0);
    q0.push_back(model(1, 2, 0, 1, 0));
    @(posedge clk); #1 en0 = 1;
    @(posedge clk); #1 en0 = 0;
    tp = -1; tf2 = -1;
    for (int c = 1; c <= 700 && tf2 < 0; c++) begin
      @(posedge clk); #1;
      en0 = (c == 100 || c == 150 || c == 200);
      if (c == 50) begin set0(3, 0, 0, 0, 1); q0.push_back(model(3, 0, 0, 0, 1)); end
      if (pr0 === 1'b1 && tp < 0) tp = c;
      else if (tp > 0 && tx0 === 1'b0) tf2 = c;
    end
    en0 = 0;
    chk("b2b_first_pronto", tp, 502);
    chk("b2b_tx_fall_after_pronto", tf2 - tp, 2);
    tf = -1;
    for (int c = tf2 - tp + 1; c <= 700 && tf < 0; c++) begin
      @(posedge clk); #1;
      if (pr0 === 1'b1) tf = c;
    end
    chk("b2b_second_pronto", tf, 502);
    bad = 0;
    repeat (600) begin @(posedge clk); #1; if (oc0 !== 1'b0 || tx0 !== 1'b1) bad++; end
    chk("b2b_no_third_frame", bad, 0);

    // reset during byte 2 with a pending request
    set0($urandom_range(0, 3), $urandom_range(0, 3), 1, 0, 0);
    @(posedge clk); #1 en0 = 1;
    @(posedge clk); #1 en0 = 0;
    for (int c = 1; c <= 260; c++) begin
      @(posedge clk); #1;
      en0 = (c == 150);
    end
    en0 = 0;
    rst0 = 1;
    @(posedge clk); #1;
    chk("abort_tx", tx0, 1);
    chk("abort_ocupado", oc0, 0);
    chk("abort_db_estado", db0, 0);
    rst0 = 0;
    bad = 0;
    repeat (700) begin @(posedge clk); #1; if (pr0 !== 1'b0 || oc0 !== 1'b0 || tx0 !== 1'b1) bad++; end
    chk("abort_quiet", bad, 0);

    // automatic frames on input change
    chk("auto_initial_done", oc1, 0);
    a1 = 1;
    q1.push_back(model(1, 0, 0, 0, 0));
    wait_pr1(tp);
    chk("auto_change_pronto", tp, 503);
    bad = 0;
    repeat (600) begin @(posedge clk); #1; if (oc1 !== 1'b0) bad++; end
    chk("auto_stable_quiet", bad, 0);
    p1 = 2; en1 = 1;
    q1.push_back(model(1, 2, 0, 0, 0));
    @(posedge clk); #1 en1 = 0;
    wait_pr1(tp);
    chk("auto_enviar_and_change_pronto", tp, 502);
    bad = 0;
    repeat (600) begin @(posedge clk); #1; if (oc1 !== 1'b0) bad++; end
    chk("auto_single_frame", bad, 0);

    chk("dut0_frames_all_seen", q0.size(), 0);
    chk("dut1_frames_all_seen", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
